// File: rtl/register_bank_mp_if.sv
// Bus bundle for register_bank_mp: write port, packed read addresses/data and sweep status.
// The master side is the pipeline (writeback drives the write port, decode drives sr).
interface register_bank_mp_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RD_PORTS = 2
);
  logic                         write;
  logic [ADDR_W-1:0]            dr;
  logic signed [DATA_W-1:0]     wrData;
  logic [RD_PORTS*ADDR_W-1:0]   sr;
  logic [RD_PORTS*DATA_W-1:0]   rData;
  logic                         busy;

  modport master (
    output write, dr, wrData, sr,
    input  rData, busy
  );

  modport slave (
    input  write, dr, wrData, sr,
    output rData, busy
  );
endinterface

// File: rtl/register_bank_mp.sv
// register_bank_mp: 2^ADDR_W x DATA_W register file with RD_PORTS asynchronous read ports and
// one synchronous write port. After reset a sequential sweep zeroes the array one entry per
// cycle so the storage needs no parallel reset and can map onto RAM.
// Optional feature: define REGBANK_BYPASS_EN to forward same-cycle write data to read ports.
module register_bank_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input logic               clk,
  input logic               reset,
  register_bank_mp_if.slave bus
);

  localparam int unsigned Depth = 1 << ADDR_W;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;

  logic [DATA_W-1:0]   mem_q [Depth];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                wr_to_zero;
  logic [DATA_W-1:0]   rd_data [RD_PORTS];

  // Entry 0 is hardwired to zero when ZERO_REG is set, so writes there are discarded.
  assign wr_to_zero = (ZERO_REG != 0) && (bus.dr == '0);

  // State register: reset (re)starts the clear sweep from entry 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StClear;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Array write port; intentionally no reset so the array can be a RAM
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Next-state: advance the sweep pointer and leave CLEAR after the last entry
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StClear: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d = StRun;
        end
      end
      StRun:   ;
      default: state_d = StClear;
    endcase
  end

  // Outputs and write-port control: sweep owns the write port while busy
  always_comb begin
    bus.busy  = (state_q == StClear);
    mem_we    = 1'b0;
    mem_waddr = bus.dr;
    mem_wdata = bus.wrData;
    if (reset) begin
      // Reset edge leaves the array untouched and drops any concurrent write
      mem_we = 1'b0;
    end else if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = '0;
    end else if (bus.write && !wr_to_zero) begin
      mem_we = 1'b1;
    end
  end

  for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = bus.sr[gi*ADDR_W +: ADDR_W];

    // Per-port read mux: sweep and zero entry force 0, optional write-through forwarding
    always_comb begin
      rd_data[gi] = mem_q[ra];
      if (state_q == StClear) begin
        rd_data[gi] = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_data[gi] = '0;
`ifdef REGBANK_BYPASS_EN
      end else if (bus.write && (ra == bus.dr) && !wr_to_zero) begin
        rd_data[gi] = bus.wrData;
`else
`endif
      end
    end
  end

  // Pack per-port read data onto the bus
  always_comb begin
    bus.rData = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      bus.rData[i*DATA_W +: DATA_W] = rd_data[i];
    end
  end

endmodule

// File: tb/tb_register_bank_mp.sv
// Directed bench for register_bank_mp: a 2-port bank with hardwired zero entry and a 4-port bank
// with an ordinary entry 0 share clock, reset and write stimulus. Expected values are queued
// as stimulus is applied and popped when the read data is sampled.
module tb_register_bank_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  register_bank_mp_if #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(2)) bus_a ();
  register_bank_mp_if #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(4)) bus_b ();

  register_bank_mp #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(2), .ZERO_REG(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  register_bank_mp #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(4), .ZERO_REG(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

`ifdef REGBANK_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_q [$];
  string         tag_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [DW-1:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_obs(input logic [DW-1:0] obs);
    string         tag;
    logic [DW-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: observed %h with nothing expected", obs);
    end else begin
      tag = tag_q.pop_front();
      e   = exp_q.pop_front();
      assert (obs === e) else begin
        n_errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  function automatic logic [DW-1:0] rd_a(input int i);
    return bus_a.rData[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rd_b(input int i);
    return bus_b.rData[i*DW +: DW];
  endfunction

  task automatic drive_wr(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_a.write  = we;
    bus_a.dr     = a;
    bus_a.wrData = d;
    bus_b.write  = we;
    bus_b.dr     = a;
    bus_b.wrData = d;
  endtask

  task automatic busy_zero_ext_check(input string tag, input logic b, input logic e);
    expect_val(tag, {{(DW-1){1'b0}}, e});
    check_obs({{(DW-1){1'b0}}, b});
  endtask

  initial begin
    int cnt;
    reset    = 1'b1;
    drive_wr(1'b0, '0, '0);
    bus_a.sr = '0;
    bus_b.sr = '0;

    // Reset held for two edges
    tick();
    busy_zero_ext_check("busy_in_reset_a", bus_a.busy, 1'b1);
    busy_zero_ext_check("busy_in_reset_b", bus_b.busy, 1'b1);
    expect_val("rdata_in_reset_a0", '0);
    check_obs(rd_a(0));
    tick();
    reset = 1'b0;

    // Sweep length, with a write attempted on sweep edge 10 and a read mid-sweep
    cnt = 0;
    while (bus_a.busy && cnt < 100) begin
      if (cnt == 9) drive_wr(1'b1, AW'(3), 32'hA5A5A5A5);
      tick();
      cnt++;
      if (cnt == 10) drive_wr(1'b0, '0, '0);
      if (cnt == 5) begin
        bus_a.sr = {AW'(3), AW'(3)};
        bus_b.sr = {AW'(3), AW'(3), AW'(3), AW'(3)};
        expect_val("read_during_sweep_a1", '0);
        expect_val("read_during_sweep_b3", '0);
        #1;
        check_obs(rd_a(1));
        check_obs(rd_b(3));
      end
    end
    expect_val("sweep_edges", 32);
    check_obs(DW'(cnt));
    busy_zero_ext_check("busy_after_sweep_b", bus_b.busy, 1'b0);

    // Every entry reads zero on every port after the sweep (r3 write was gated)
    for (int a = 0; a < 32; a++) begin
      bus_a.sr = {AW'(31 - a), AW'(a)};
      bus_b.sr = {AW'(31 - a), AW'(a), AW'(31 - a), AW'(a)};
      expect_val("cleared_a0", '0);
      expect_val("cleared_a1", '0);
      for (int p = 0; p < 4; p++) expect_val("cleared_b", '0);
      #1;
      check_obs(rd_a(0));
      check_obs(rd_a(1));
      for (int p = 0; p < 4; p++) check_obs(rd_b(p));
    end

    // Write r5 and r31, then read back on multiple ports
    drive_wr(1'b1, AW'(5), 32'hDEADBEEF);
    tick();
    drive_wr(1'b1, AW'(31), 32'hFFFFFFFF);
    tick();
    drive_wr(1'b0, '0, '0);
    bus_a.sr = {AW'(31), AW'(5)};
    bus_b.sr = {AW'(5), AW'(5), AW'(5), AW'(5)};
    expect_val("rd_r5_a0", 32'hDEADBEEF);
    expect_val("rd_r31_a1", 32'hFFFFFFFF);
    for (int p = 0; p < 4; p++) expect_val("rd_r5_b_all", 32'hDEADBEEF);
    #1;
    check_obs(rd_a(0));
    check_obs(rd_a(1));
    for (int p = 0; p < 4; p++) check_obs(rd_b(p));

    // Entry 0: hardwired in bank A, ordinary in bank B
    drive_wr(1'b1, AW'(0), 32'h12345678);
    tick();
    drive_wr(1'b0, '0, '0);
    bus_a.sr = {AW'(0), AW'(0)};
    bus_b.sr = {AW'(0), AW'(0), AW'(31), AW'(0)};
    expect_val("zero_reg_a0", '0);
    expect_val("zero_reg_a1", '0);
    expect_val("plain_r0_b0", 32'h12345678);
    expect_val("plain_r31_b1", 32'hFFFFFFFF);
    #1;
    check_obs(rd_a(0));
    check_obs(rd_a(1));
    check_obs(rd_b(0));
    check_obs(rd_b(1));

    // Same-cycle read of the address being written
    drive_wr(1'b1, AW'(9), 32'h000055AA);
    bus_a.sr = {AW'(5), AW'(9)};
    bus_b.sr = {AW'(9), AW'(9), AW'(9), AW'(9)};
    expect_val("same_cycle_r9_a0", Bypass ? 32'h000055AA : 32'h0);
    expect_val("same_cycle_other_a1", 32'hDEADBEEF);
    expect_val("same_cycle_r9_b2", Bypass ? 32'h000055AA : 32'h0);
    #1;
    check_obs(rd_a(0));
    check_obs(rd_a(1));
    check_obs(rd_b(2));
    tick();
    drive_wr(1'b0, '0, '0);
    expect_val("next_cycle_r9_a0", 32'h000055AA);
    expect_val("next_cycle_r9_b0", 32'h000055AA);
    #1;
    check_obs(rd_a(0));
    check_obs(rd_b(0));

    // Same-cycle write to entry 0: never forwarded when hardwired
    drive_wr(1'b1, AW'(0), 32'h0000BEEF);
    bus_a.sr = {AW'(0), AW'(0)};
    bus_b.sr = {AW'(0), AW'(0), AW'(0), AW'(0)};
    expect_val("same_cycle_r0_a0", '0);
    expect_val("same_cycle_r0_b0", Bypass ? 32'h0000BEEF : 32'h12345678);
    #1;
    check_obs(rd_a(0));
    check_obs(rd_b(0));
    tick();
    drive_wr(1'b0, '0, '0);
    expect_val("after_r0_a0", '0);
    expect_val("after_r0_b0", 32'h0000BEEF);
    #1;
    check_obs(rd_a(0));
    check_obs(rd_b(0));

    // Reset in RUN, then a second reset at sweep edge 20
    drive_wr(1'b1, AW'(7), 32'h1);
    tick();
    drive_wr(1'b0, '0, '0);
    bus_a.sr = {AW'(7), AW'(7)};
    bus_b.sr = {AW'(7), AW'(7), AW'(7), AW'(7)};
    expect_val("r7_before_reset_a0", 32'h1);
    expect_val("r7_before_reset_b0", 32'h1);
    #1;
    check_obs(rd_a(0));
    check_obs(rd_b(0));

    reset = 1'b1;
    drive_wr(1'b1, AW'(9), 32'hFFFF);
    tick();
    reset = 1'b0;
    drive_wr(1'b0, '0, '0);
    busy_zero_ext_check("busy_after_run_reset_a", bus_a.busy, 1'b1);
    expect_val("r7_gated_a0", '0);
    expect_val("r7_gated_b0", '0);
    check_obs(rd_a(0));
    check_obs(rd_b(0));

    for (int k = 1; k < 20; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    busy_zero_ext_check("busy_after_mid_reset_b", bus_b.busy, 1'b1);
    cnt = 0;
    while (bus_a.busy && cnt < 100) begin
      tick();
      cnt++;
    end
    expect_val("restarted_sweep_edges", 32);
    check_obs(DW'(cnt));

    bus_a.sr = {AW'(5), AW'(7)};
    bus_b.sr = {AW'(31), AW'(9), AW'(5), AW'(7)};
    expect_val("r7_cleared_a0", '0);
    expect_val("r5_cleared_a1", '0);
    for (int p = 0; p < 4; p++) expect_val("recleared_b", '0);
    #1;
    check_obs(rd_a(0));
    check_obs(rd_a(1));
    for (int p = 0; p < 4; p++) check_obs(rd_b(p));

    if (exp_q.size() != 0) begin
      n_errors++;
      $error("FAIL scoreboard_leftover: observed %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
